// File: rtl/pwm_duty_feeder.sv
// Duty-sample FIFO feeding the PWM generator: one new duty value per PWM period, aligned to tick.
// Optional per-period slew limiting is enabled by defining PWM_FEEDER_SLEW_EN.
module pwm_duty_feeder #(
   parameter int unsigned DW       = 10,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned MAX_STEP = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DW-1:0]         s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic                         tick,
   output logic signed [DW-1:0]         duty,
   output logic                         underrun,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [LW-1:0] HALF = LW'(DEPTH / 2);

   // Elaboration-time sanity checks on the configuration
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("pwm_duty_feeder: DEPTH must be a power of two >= 2");
   end
   if ((MAX_STEP < 1) || (MAX_STEP > ((1 << (DW - 1)) - 1))) begin : g_bad_step
      $error("pwm_duty_feeder: MAX_STEP out of range");
   end

   typedef enum logic {
      PRIME,
      RUN
   } state_t;

   state_t               state, state_next;
   logic signed [DW-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        count, count_next;
   logic                 push, pop, underrun_next;
   logic signed [DW-1:0] head, duty_next;

   assign head    = mem[rd_ptr];
   assign level   = count;
   assign s_ready = (count != FULL);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PRIME;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      push          = s_valid && s_ready;
      pop           = 1'b0;
      underrun_next = 1'b0;
      unique case (state)
         PRIME: begin
            if (count >= HALF) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (tick) begin
               // A push landing on an empty-FIFO tick is not bypassed
               if (count != '0) begin
                  pop = 1'b1;
               end else begin
                  underrun_next = 1'b1;
               end
            end
         end
         default: state_next = PRIME;
      endcase
   end

   // ---------------------------------------------------------------- FIFO
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   // ---------------------------------------------------------------- duty update
`ifdef PWM_FEEDER_SLEW_EN
   localparam logic signed [DW:0] STEP_POS = (DW+1)'(MAX_STEP);
   localparam logic signed [DW:0] STEP_NEG = -STEP_POS;

   logic signed [DW:0] diff, step, sum;

   // Moving toward head never overshoots it, so sum always fits in DW bits
   always_comb begin
      diff = {head[DW-1], head} - {duty[DW-1], duty};
      if (diff > STEP_POS) begin
         step = STEP_POS;
      end else if (diff < STEP_NEG) begin
         step = STEP_NEG;
      end else begin
         step = diff;
      end
      sum       = {duty[DW-1], duty} + step;
      duty_next = sum[DW-1:0];
   end
`else
   always_comb begin
      duty_next = head;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty     <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= underrun_next;
         if (pop) begin
            duty <= duty_next;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Self-checking bench for pwm_duty_feeder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pwm_duty_feeder;

   localparam int DW       = 10;
   localparam int DEPTH    = 8;
   localparam int MAX_STEP = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic signed [DW-1:0] s_data = '0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic                 tick = 1'b0;
   logic signed [DW-1:0] duty;
   logic                 underrun;
   logic [3:0]           level;

   int n_pass  = 0;
   int n_total = 0;
   bit started = 1'b0;

   pwm_duty_feeder #(.DW(DW), .DEPTH(DEPTH), .MAX_STEP(MAX_STEP)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tick(tick), .duty(duty), .underrun(underrun), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------ reference model
   int  q[$];
   bit  m_run;
   int  m_duty;
   bit  m_under;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_run   = 1'b0;
         m_duty  = 0;
         m_under = 1'b0;
      end else begin
         int lvl;
         bit acc;
         lvl = q.size();
         acc = s_valid && (lvl < DEPTH);
         m_under = 1'b0;
         if (m_run && tick) begin
            if (lvl > 0) begin
               int head;
               head = q.pop_front();
`ifdef PWM_FEEDER_SLEW_EN
               begin
                  int d;
                  d = head - m_duty;
                  if (d > MAX_STEP) d = MAX_STEP;
                  if (d < -MAX_STEP) d = -MAX_STEP;
                  m_duty = m_duty + d;
               end
`else
               m_duty = head;
`endif
            end else begin
               m_under = 1'b1;
            end
         end
         if (acc) q.push_back(int'($signed(s_data)));
         if (lvl >= DEPTH / 2) m_run = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("cyc_duty", int'($signed(duty)), m_duty);
         check("cyc_underrun", int'(underrun), int'(m_under));
         check("cyc_level", int'(level), q.size());
         check("cyc_s_ready", int'(s_ready), int'(q.size() < DEPTH));
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic cyc(input bit v, input int d, input bit t);
      s_valid = v;
      s_data  = DW'(d);
      tick    = t;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      tick    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_duty", int'($signed(duty)), 0);
      check("rst_level", int'(level), 0);
      check("rst_s_ready", int'(s_ready), 1);
      check("rst_underrun", int'(underrun), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int vals[8];
      vals = '{100, -200, 511, -512, 0, 1, 2, 3};
      #2;
      rst_n   = 1'b0;
      started = 1'b1;
      do_reset();

`ifndef PWM_FEEDER_SLEW_EN
      // Priming: three samples are not enough to start
      cyc(1, 10, 0); cyc(1, 20, 0); cyc(1, 30, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1);
         check("prime_duty", int'($signed(duty)), 0);
         check("prime_under", int'(underrun), 0);
      end
      cyc(1, 40, 0);
      check("prime_level4", int'(level), 4);
      cyc(0, 0, 0);
      check("prime_pre_tick", int'($signed(duty)), 0);
      cyc(0, 0, 1);
      check("prime_first_pop", int'($signed(duty)), 10);
      for (int i = 2; i <= 4; i++) begin
         cyc(0, 0, 1);
         check("prime_drain", int'($signed(duty)), i * 10);
      end

      // Underrun on empty FIFO
      cyc(0, 0, 1);
      check("ur_pulse", int'(underrun), 1);
      check("ur_hold", int'($signed(duty)), 40);
      check("ur_level", int'(level), 0);
      cyc(0, 0, 0);
      check("ur_one_cycle", int'(underrun), 0);
      cyc(1, 50, 0);
      cyc(0, 0, 1);
      check("ur_refill", int'($signed(duty)), 50);
      check("ur_refill_no_ur", int'(underrun), 0);

      // Push coinciding with an empty tick: stored, not bypassed
      cyc(1, 60, 1);
      check("nobypass_ur", int'(underrun), 1);
      check("nobypass_duty", int'($signed(duty)), 50);
      check("nobypass_level", int'(level), 1);
      cyc(0, 0, 1);
      check("nobypass_next", int'($signed(duty)), 60);

      // Ordering, full, and extreme values
      foreach (vals[i]) cyc(1, vals[i], 0);
      check("full_level", int'(level), 8);
      check("full_ready", int'(s_ready), 0);
      cyc(1, 999, 0);
      check("full_reject", int'(level), 8);
      foreach (vals[i]) begin
         cyc(0, 0, 1);
         check("order_duty", int'($signed(duty)), vals[i]);
         if (i == 0) check("ready_after_pop", int'(s_ready), 1);
      end

      // Simultaneous push and pop
      for (int i = 11; i <= 14; i++) cyc(1, i, 0);
      check("sim_level_pre", int'(level), 4);
      cyc(1, 15, 1);
      check("sim_level", int'(level), 4);
      check("sim_oldest", int'($signed(duty)), 11);
      for (int i = 12; i <= 15; i++) begin
         cyc(0, 0, 1);
         check("sim_drain", int'($signed(duty)), i);
      end

      // Mid-operation reset
      cyc(1, 300, 0);
      cyc(0, 0, 1);
      check("mr_duty300", int'($signed(duty)), 300);
      for (int i = 1; i <= 5; i++) cyc(1, i, 0);
      check("mr_level5", int'(level), 5);
      rst_n = 1'b0;
      #1;
      check("mr_async_duty", int'($signed(duty)), 0);
      check("mr_async_level", int'(level), 0);
      check("mr_async_ready", int'(s_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 1);
      check("mr_reprime_duty", int'($signed(duty)), 0);
      check("mr_reprime_ur", int'(underrun), 0);
`else
      // Slew-limited updates
      cyc(1, 400, 0); cyc(1, 400, 0); cyc(1, -512, 0); cyc(1, 7, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      check("slew_1", int'($signed(duty)), 16);
      cyc(0, 0, 1);
      check("slew_2", int'($signed(duty)), 32);
      cyc(0, 0, 1);
      check("slew_3", int'($signed(duty)), 16);
      cyc(0, 0, 1);
      check("slew_4", int'($signed(duty)), 7);
      check("slew_level", int'(level), 0);
`endif

      repeat (3) cyc(0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pwm_duty_feeder.md
# pwm_duty_feeder

Upstream duty-sample buffer for the PWM generator. Accepts signed duty samples over a valid/ready stream, buffers them in a small FIFO, and presents exactly one new value on `duty` per PWM period, aligned to the generator's `tick`. `duty` connects directly to the generator's `in` port. Because the update is timed to the generator's period boundary, the compare value never changes mid-period.

## Interface
- `DW`, 10: sample and duty width (signed, two's complement); must equal the PWM generator's `DW`.
- `DEPTH`, 8: FIFO depth in entries; power of two, ≥ 2.
- `MAX_STEP`, 16: maximum per-period duty change; used only when `PWM_FEEDER_SLEW_EN` is defined; 1 ≤ `MAX_STEP` ≤ 2^(DW-1)−1.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_data` input DW: signed duty sample.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: FIFO can accept a sample.
- `tick` input 1: period-boundary pulse from the PWM generator (high for one cycle when its counter is at peak).
- `duty` output DW: signed duty value to the generator's `in`.
- `underrun` output 1: one-cycle pulse when a RUN-state tick finds the FIFO empty.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- FIFO:
  - Circular buffer with read and write pointers and an occupancy count.
  - Push when `s_valid && s_ready`.
  - `s_ready = (level != DEPTH)`, combinational from the registered count.
- State machine, two states:
  - PRIME (reset state):
    - Ticks are ignored: no pop, `duty` holds, no `underrun`.
    - Move to RUN in the cycle after `level` ≥ DEPTH/2.
  - RUN:
    - On each `tick`, if `level` > 0: pop the head entry and load it into `duty`.
    - On each `tick`, if `level` == 0: `duty` holds its value, `underrun` = 1 for one cycle, state stays RUN.
    - The block never returns to PRIME except through reset.
- Simultaneous push and pop (RUN, tick, 0 < `level` < DEPTH): both occur and `level` is unchanged.
- Push in the same cycle as a tick with `level` == 0:
  - No bypass; this counts as an underrun.
  - The sample is stored and popped on the next tick.
- Full FIFO: `s_ready` = 0. A pop on that cycle frees an entry, so `s_ready` = 1 from the next cycle.
- Arithmetic:
  - `duty` is loaded as-is, with no scaling or saturation.
  - The full signed range −2^(DW-1) .. 2^(DW-1)−1 passes through unchanged.

## Timing
- Reset (async assert, sync release): `duty` = 0, `underrun` = 0, `level` = 0, `s_ready` = 1, state = PRIME, pointers = 0.
- Latency:
  - `tick` at cycle N → new `duty` visible at N+1.
  - `duty` therefore changes on the first cycle of the generator's next period.
- Push at cycle N → `level` increments at N+1.
- `underrun` is registered: asserted at N+1 for a tick at N.
- Reset asserted mid-operation: FIFO contents are discarded, all outputs go to reset values immediately, and a full re-prime is required.
- `tick` on consecutive cycles is legal: each tick is handled independently.

## Configuration
- `PWM_FEEDER_SLEW_EN` defined:
  - On a RUN pop, `duty <= duty + clamp(head − duty, −MAX_STEP, +MAX_STEP)`.
  - The difference is computed in DW+1 bits; the result always stays within the DW-bit range.
  - The head entry is consumed even when the target is not reached.
- `PWM_FEEDER_SLEW_EN` undefined: `duty <= head` directly, and `MAX_STEP` is unused.

## Test plan
(All scenarios use DW=10, DEPTH=8, MAX_STEP=16, and release from reset unless stated.)
- Priming:
  - Stimulus: push 3 samples, apply ticks.
  - Required: `duty` stays 0 and `underrun` stays 0.
  - Stimulus: push a 4th sample.
  - Required: RUN is entered; the next tick loads sample 1 one cycle after the tick.
- Ordering and full:
  - Stimulus: push 100, −200, 511, −512, 0, 1, 2, 3.
  - Required: `level` = 8 and `s_ready` = 0.
  - Stimulus: 8 ticks.
  - Required: `duty` follows exactly that sequence, and `s_ready` = 1 the cycle after the first pop.
- Underrun:
  - Stimulus: in RUN, drain the FIFO, then tick.
  - Required: `duty` holds its last value, `underrun` is high for exactly 1 cycle, and `level` = 0.
  - Stimulus: push 50, then tick.
  - Required: `duty` = 50.
- Simultaneous events:
  - Stimulus: in RUN at `level` = 4, push and tick in the same cycle.
  - Required: `level` stays 4 and the popped value is the oldest entry.
- Mid-operation reset:
  - Stimulus: `rst_n` low for 1 cycle with `level` = 5 and `duty` = 300.
  - Required: outputs return to reset values asynchronously, and a tick after release leaves `duty` = 0.
- Slew (`PWM_FEEDER_SLEW_EN` defined):
  - Stimulus: prime, then tick on entries 400, 400, −512.
  - Required: `duty` = 16, then 32, then 16.
